// File: rtl/spi_stream_router_pkg.sv
// Shared types and opcodes for the SPI stream router.
package spi_stream_router_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PASS = 2'd1,
        ST_LOAD = 2'd2
    } state_t;

    localparam logic [1:0] HDR_CHAN = 2'b11;
    localparam logic [1:0] HDR_I2S  = 2'b10;

    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/spi_stream_router_if.sv
// Byte-level link between the SPI byte engine (master) and the router (slave).
interface spi_stream_router_if;
    logic       rx_ready;
    logic [7:0] rx_byte;
    logic [7:0] tx_byte;

    modport master (output rx_ready, output rx_byte, input tx_byte);
    modport slave  (input rx_ready, input rx_byte, output tx_byte);
endinterface

// File: rtl/spi_stream_router_timer.sv
// activity_timer: counts idle cycles while enabled, flags expiry at TIMEOUT_CYC-1.
module activity_timer #(
    parameter int unsigned TIMEOUT_CYC = 25000000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic enable,
    input  logic clear,
    output logic expire
);
    localparam int CNT_W = $clog2(TIMEOUT_CYC);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign expire = enable && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

    // Holding at terminal count keeps the counter from wrapping if the owner lingers.
    always_comb begin
        cnt_d = cnt_q;
        if (clear || !enable)
            cnt_d = '0;
        else if (!expire)
            cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end
endmodule

// File: rtl/spi_stream_router.sv
// Routes SPI bytes to one of NCH byte channels or into an i2s sample pair.
// Optional status readback and header error counter: define ROUTER_STATUS_EN.
//   state   | meaning
//   IDLE    | waiting for a header byte
//   PASS    | forwarding bytes to the selected channel, echoing its read byte
//   LOAD    | shifting bytes into the left/right sample shadow
module spi_stream_router
    import spi_stream_router_pkg::*;
#(
    parameter int NCH         = 4,
    parameter int SAMPLE_W    = 16,
    parameter int TIMEOUT_CYC = 25000000
) (
    input  logic                  clk,
    input  logic                  reset_n,
    spi_stream_router_if.slave    spi,
    output logic [NCH-1:0]        ch_sel_o,
    output logic [7:0]            ch_data_o,
    output logic                  ch_wr_o,
    input  logic [8*NCH-1:0]      ch_rd_data_i,
    output logic [SAMPLE_W-1:0]   i2s_left_o,
    output logic [SAMPLE_W-1:0]   i2s_right_o,
    output logic                  sample_valid_o
);
    localparam int CH_W = ch_width(NCH);
    localparam int NB   = SAMPLE_W / 4;

    if (NCH < 1 || NCH > 16 || SAMPLE_W % 8 != 0 || SAMPLE_W < 8 || SAMPLE_W > 32
        || TIMEOUT_CYC < 2) begin : g_param_check
        $error("spi_stream_router: parameter out of range");
    end

    state_t                  state_q, state_d;
    logic [CH_W-1:0]         chan_q, chan_d;
    logic [NCH-1:0]          ch_sel_q, ch_sel_d;
    logic [7:0]              ch_data_q, ch_data_d;
    logic                    ch_wr_q, ch_wr_d;
    logic [7:0]              tx_q, tx_d;
    logic [2*SAMPLE_W-1:0]   shadow_q, shadow_d;
    logic [3:0]              bcnt_q, bcnt_d;
    logic [SAMPLE_W-1:0]     left_q, left_d, right_q, right_d;
    logic                    sv_q, sv_d;
    logic [3:0]              err_q, err_d;
    logic                    expire;

    activity_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .enable  (state_q != ST_IDLE),
        .clear   (spi.rx_ready),
        .expire  (expire)
    );

    always_comb begin
        state_d   = state_q;
        chan_d    = chan_q;
        ch_data_d = ch_data_q;
        ch_wr_d   = 1'b0;
        shadow_d  = shadow_q;
        bcnt_d    = bcnt_q;
        left_d    = left_q;
        right_d   = right_q;
        sv_d      = 1'b0;
        err_d     = err_q;
        case (state_q)
            ST_IDLE: begin
                if (spi.rx_ready) begin
                    // Whole 6-bit field is range-checked so out-of-range codes never alias.
                    if (spi.rx_byte[7:6] == HDR_CHAN) begin
                        if (spi.rx_byte[5:0] < 6'(NCH)) begin
                            state_d = ST_PASS;
                            chan_d  = spi.rx_byte[CH_W-1:0];
                        end else if (err_q != 4'hF) begin
                            err_d = err_q + 4'd1;
                        end
                    end else if (spi.rx_byte[7:6] == HDR_I2S) begin
                        state_d = ST_LOAD;
                        bcnt_d  = 4'd0;
                    end
`ifdef ROUTER_STATUS_EN
                    else if (spi.rx_byte == 8'h00) begin
                        err_d = 4'd0;
                    end
`endif
                end
            end
            ST_PASS: begin
                if (spi.rx_ready) begin
                    ch_data_d = spi.rx_byte;
                    ch_wr_d   = 1'b1;
                end else if (expire) begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (spi.rx_ready) begin
                    shadow_d = {shadow_q[2*SAMPLE_W-9:0], spi.rx_byte};
                    bcnt_d   = bcnt_q + 4'd1;
                    if (bcnt_q == 4'(NB - 1)) begin
                        left_d  = shadow_d[2*SAMPLE_W-1:SAMPLE_W];
                        right_d = shadow_d[SAMPLE_W-1:0];
                        sv_d    = 1'b1;
                        state_d = ST_IDLE;
                    end
                end else if (expire) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        ch_sel_d = (state_d == ST_PASS) ? (NCH'(1) << chan_d) : '0;

        if (state_q == ST_PASS)
            tx_d = ch_rd_data_i[8*int'(chan_q) +: 8];
        else
`ifdef ROUTER_STATUS_EN
            tx_d = {state_q, 2'b00, err_q};
`else
            tx_d = 8'h00;
`endif
    end

`ifndef ROUTER_STATUS_EN
    logic unused_err;
    assign unused_err = ^err_d;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            chan_q    <= '0;
            ch_sel_q  <= '0;
            ch_data_q <= '0;
            ch_wr_q   <= 1'b0;
            tx_q      <= '0;
            shadow_q  <= '0;
            bcnt_q    <= '0;
            left_q    <= '0;
            right_q   <= '0;
            sv_q      <= 1'b0;
`ifdef ROUTER_STATUS_EN
            err_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            chan_q    <= chan_d;
            ch_sel_q  <= ch_sel_d;
            ch_data_q <= ch_data_d;
            ch_wr_q   <= ch_wr_d;
            tx_q      <= tx_d;
            shadow_q  <= shadow_d;
            bcnt_q    <= bcnt_d;
            left_q    <= left_d;
            right_q   <= right_d;
            sv_q      <= sv_d;
`ifdef ROUTER_STATUS_EN
            err_q     <= err_d;
`endif
        end
    end

`ifndef ROUTER_STATUS_EN
    assign err_q = 4'd0;
`endif

    assign ch_sel_o       = ch_sel_q;
    assign ch_data_o      = ch_data_q;
    assign ch_wr_o        = ch_wr_q;
    assign spi.tx_byte    = tx_q;
    assign i2s_left_o     = left_q;
    assign i2s_right_o    = right_q;
    assign sample_valid_o = sv_q;
endmodule

// File: tb/tb_spi_stream_router.sv
// Directed bench for spi_stream_router (NCH=4, SAMPLE_W=16, TIMEOUT_CYC=100).
module tb_spi_stream_router;
    localparam int NCH = 4;
    localparam int SW  = 16;
    localparam int TC  = 100;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [NCH-1:0]    ch_sel_o;
    logic [7:0]        ch_data_o;
    logic              ch_wr_o;
    logic [8*NCH-1:0]  ch_rd_data_i;
    logic [SW-1:0]     i2s_left_o, i2s_right_o;
    logic              sample_valid_o;

    int checks = 0;
    int errors = 0;
    int sv_cnt = 0;
    logic [7:0] wr_log[$];
    logic [7:0] exp_wr[4];

    spi_stream_router_if spi_if();

    spi_stream_router #(.NCH(NCH), .SAMPLE_W(SW), .TIMEOUT_CYC(TC)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .spi            (spi_if),
        .ch_sel_o       (ch_sel_o),
        .ch_data_o      (ch_data_o),
        .ch_wr_o        (ch_wr_o),
        .ch_rd_data_i   (ch_rd_data_i),
        .i2s_left_o     (i2s_left_o),
        .i2s_right_o    (i2s_right_o),
        .sample_valid_o (sample_valid_o)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (reset_n) begin
            if (ch_wr_o) wr_log.push_back(ch_data_o);
            if (sample_valid_o) sv_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        spi_if.rx_ready = 1'b1;
        spi_if.rx_byte  = b;
        @(negedge clk);
        spi_if.rx_ready = 1'b0;
        spi_if.rx_byte  = 8'h00;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        reset_n         = 1'b0;
        spi_if.rx_ready = 1'b0;
        spi_if.rx_byte  = 8'h00;
        ch_rd_data_i    = 32'h44332211;
        idle(2);
        check("rst_sel",   32'(ch_sel_o), 32'h0);
        check("rst_wr",    32'(ch_wr_o), 32'h0);
        check("rst_tx",    32'(spi_if.tx_byte), 32'h0);
        check("rst_left",  32'(i2s_left_o), 32'h0);
        check("rst_right", 32'(i2s_right_o), 32'h0);
        check("rst_sv",    32'(sample_valid_o), 32'h0);
        reset_n = 1'b1;

        // channel pass-through, header-like bytes forwarded verbatim
        send(8'hC2);
        check("pass_sel", 32'(ch_sel_o), 32'b0100);
        send(8'h5A);
        send(8'hA5);
        send(8'hC0);
        send(8'h80);
        idle(1);
        check("pass_sel_hold", 32'(ch_sel_o), 32'b0100);
        check("pass_wr_count", 32'(wr_log.size()), 32'd4);
        exp_wr = '{8'h5A, 8'hA5, 8'hC0, 8'h80};
        for (int i = 0; i < 4 && i < wr_log.size(); i++)
            check($sformatf("pass_wr_data%0d", i), 32'(wr_log[i]), 32'(exp_wr[i]));
        check("pass_tx", 32'(spi_if.tx_byte), 32'h33);
        ch_rd_data_i = 32'h44BB2211;
        idle(1);
        check("pass_tx_follow", 32'(spi_if.tx_byte), 32'hBB);
        ch_rd_data_i = 32'h44332211;
        idle(TC + 5);
        check("pass_timeout_sel", 32'(ch_sel_o), 32'h0);
        check("idle_tx", 32'(spi_if.tx_byte), 32'h0);

        // sample load
        wr_log.delete();
        send(8'h80);
        send(8'h12);
        send(8'h34);
        send(8'h56);
        check("load_no_early_sv", 32'(sample_valid_o), 32'h0);
        send(8'h78);
        check("load_sv", 32'(sample_valid_o), 32'h1);
        check("load_left",  32'(i2s_left_o), 32'h1234);
        check("load_right", 32'(i2s_right_o), 32'h5678);
        idle(1);
        check("load_sv_pulse", 32'(sample_valid_o), 32'h0);
        check("load_sv_count", 32'(sv_cnt), 32'd1);
        send(8'hC0);
        check("load_back_idle", 32'(ch_sel_o), 32'b0001);
        check("load_no_wr", 32'(wr_log.size()), 32'd0);
        idle(TC + 5);

        // exact timeout distance
        send(8'hC1);
        check("to_sel", 32'(ch_sel_o), 32'b0010);
        idle(TC - 1);
        check("to_before", 32'(ch_sel_o), 32'b0010);
        idle(1);
        check("to_expire", 32'(ch_sel_o), 32'h0);

        // partial load discarded on timeout
        send(8'h80);
        send(8'h11);
        idle(TC + 5);
        check("partial_sv_count", 32'(sv_cnt), 32'd1);
        check("partial_left",  32'(i2s_left_o), 32'h1234);
        check("partial_right", 32'(i2s_right_o), 32'h5678);
        send(8'h80);
        send(8'hAA);
        send(8'hBB);
        send(8'hCC);
        send(8'hDD);
        check("reload_left",  32'(i2s_left_o), 32'hAABB);
        check("reload_right", 32'(i2s_right_o), 32'hCCDD);
        idle(1);
        check("reload_sv_count", 32'(sv_cnt), 32'd2);

        // out-of-range channel header
        send(8'hC7);
        check("bad_ch_sel", 32'(ch_sel_o), 32'h0);
        idle(1);
`ifdef ROUTER_STATUS_EN
        check("bad_ch_status", 32'(spi_if.tx_byte), 32'h01);
        send(8'h00);
        idle(1);
        check("err_clear", 32'(spi_if.tx_byte), 32'h00);
`else
        check("bad_ch_tx", 32'(spi_if.tx_byte), 32'h00);
`endif
        send(8'hC3);
        check("after_bad_sel", 32'(ch_sel_o), 32'b1000);

        // strobe coincident with expiry wins
        idle(TC - 1);
        spi_if.rx_ready = 1'b1;
        spi_if.rx_byte  = 8'h3C;
        @(negedge clk);
        spi_if.rx_ready = 1'b0;
        spi_if.rx_byte  = 8'h00;
        check("race_wr",   32'(ch_wr_o), 32'h1);
        check("race_data", 32'(ch_data_o), 32'h3C);
        check("race_sel",  32'(ch_sel_o), 32'b1000);
        idle(60);
        check("race_timer_cleared", 32'(ch_sel_o), 32'b1000);
        idle(TC);
        check("race_final_idle", 32'(ch_sel_o), 32'h0);

        // reset mid-load
        send(8'h80);
        send(8'h01);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("mid_rst_left",  32'(i2s_left_o), 32'h0);
        check("mid_rst_right", 32'(i2s_right_o), 32'h0);
        check("mid_rst_sel",   32'(ch_sel_o), 32'h0);
        check("mid_rst_tx",    32'(spi_if.tx_byte), 32'h0);
        check("mid_rst_sv",    32'(sample_valid_o), 32'h0);
        idle(2);
        reset_n = 1'b1;
        send(8'h80);
        send(8'h11);
        send(8'h22);
        send(8'h33);
        send(8'h44);
        check("post_rst_left",  32'(i2s_left_o), 32'h1122);
        check("post_rst_right", 32'(i2s_right_o), 32'h3344);
        idle(1);
        check("post_rst_sv_count", 32'(sv_cnt), 32'd3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
